// File: rtl/led_blink_sched.sv
// led_blink_sched: one status LED shared by NREQ requesters.
// Round-robin grant, then an ON/OFF/GAP burst sequencer.
module led_blink_sched #(
    parameter int NREQ  = 4,
    parameter int NBITS = 3,
    parameter int CBITS = 12,
    parameter int PHASE = 2048,
    parameter int GAP   = 4095,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NBITS-1:0] req_cnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  led,
    output logic                  flg
);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP_S
    } state_t;

    localparam logic [CBITS-1:0] PH_END  = CBITS'(PHASE - 1);
    localparam logic [CBITS-1:0] GAP_END = CBITS'(GAP - 1);

    state_t           state;
    state_t           state_next;
    logic [CBITS-1:0] timer;
    logic [CBITS-1:0] timer_next;
    logic [NBITS-1:0] remaining;
    logic [NBITS-1:0] rem_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   gid_next;
    logic [NREQ-1:0]  ack_next;
    logic             led_next;
    logic             flg_next;

    logic [NBITS-1:0] cnt_arr [NREQ];
    logic [IDW-1:0]   win;
    logic             found;
    logic [IDW-1:0]   idx;

    // Split the packed count bus into one field per requester
    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign cnt_arr[g] = req_cnt[g*NBITS +: NBITS];
    end

    // Round-robin scan starting just after the last owner
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (idx == IDW'(NREQ - 1)) begin
                idx = '0;
            end else begin
                idx = idx + IDW'(1);
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic for the burst sequencer
    always_comb begin
        state_next = state;
        timer_next = timer;
        rem_next   = remaining;
        ptr_next   = ptr;
        gid_next   = grant_id;
        ack_next   = '0;
        unique case (state)
            IDLE: begin
                // the ack cycle is skipped so the finished owner can drop req
                if (found && ack == '0) begin
                    ptr_next   = win;
                    gid_next   = win;
                    rem_next   = cnt_arr[win];
                    timer_next = '0;
                    if (cnt_arr[win] != '0) begin
                        state_next = ON;
                    end else begin
                        ack_next = NREQ'(1) << win;
                    end
                end
            end
            ON: begin
                if (timer == PH_END) begin
                    timer_next = '0;
                    rem_next   = remaining - NBITS'(1);
                    state_next = OFF;
                end else begin
                    timer_next = timer + CBITS'(1);
                end
            end
            OFF: begin
                if (timer == PH_END) begin
                    timer_next = '0;
                    if (remaining != '0) begin
                        state_next = ON;
                    end else begin
                        state_next = GAP_S;
                    end
                end else begin
                    timer_next = timer + CBITS'(1);
                end
            end
            GAP_S: begin
                if (timer == GAP_END) begin
                    timer_next = '0;
                    state_next = IDLE;
                    ack_next[grant_id] = 1'b1;
                end else begin
                    timer_next = timer + CBITS'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
        led_next = (state_next == ON);
        flg_next = (led_next != led);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
            ptr       <= IDW'(NREQ - 1);
            grant_id  <= '0;
            ack       <= '0;
            led       <= 1'b0;
            flg       <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            remaining <= rem_next;
            ptr       <= ptr_next;
            grant_id  <= gid_next;
            ack       <= ack_next;
            led       <= led_next;
            flg       <= flg_next;
        end
    end

    assign busy = (state != IDLE);

endmodule
